// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: DEPTH x 32-bit words, fixed wait states per OKAY
// transfer, two-cycle ERROR response for out-of-range/misaligned/oversized accesses.
module ahb_slave_mem #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic        Hsel,
  input  logic [31:0] Haddr,
  input  logic [1:0]  Htrans,
  input  logic        Hwrite,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Hwdata,
  input  logic        Hready,
  output logic        Hreadyout,
  output logic        Hresp,
  output logic [31:0] Hrdata
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [1:0] WLOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state, w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [IW-1:0] r_idx;
  logic          r_write;
  logic [1:0]    r_size;
  logic [1:0]    r_lane;
  logic [1:0]    r_wcnt;

  logic [29:0]   w_woff;
  logic          w_legal, w_open, w_accept;
  logic [3:0]    w_be;
  logic          w_unused_htrans0;

  assign w_unused_htrans0 = Htrans[0];

  // Word offset from base; addresses below base are rejected separately.
  assign w_woff  = Haddr[31:2] - BASE_ADDR[31:2];
  assign w_legal = (Haddr >= BASE_ADDR) && (w_woff < 30'(DEPTH)) &&
                   (Hsize <= 3'b010) &&
                   !((Hsize == 3'b001) && Haddr[0]) &&
                   !((Hsize == 3'b010) && (Haddr[1:0] != 2'b00));

  // A new address phase can only land where the slave is driving ready high.
  assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept = w_open && Hsel && Htrans[1] && Hready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!w_accept)    w_next = S_IDLE;
        else if (!w_legal) w_next = S_ERR1;
        else              w_next = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
      end
      S_WAIT:  w_next = (r_wcnt == 2'd0) ? S_DATA : S_WAIT;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'b00:   w_be = 4'b0001 << r_lane;
      2'b01:   w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_write <= 1'b0;
      r_size  <= 2'b00;
      r_lane  <= 2'b00;
      r_wcnt  <= 2'd0;
    end else begin
      r_state <= w_next;
      if (w_accept && w_legal) begin
        r_idx   <= w_woff[IW-1:0];
        r_write <= Hwrite;
        r_size  <= Hsize[1:0];
        r_lane  <= Haddr[1:0];
      end
      if (w_next == S_WAIT && r_state != S_WAIT) r_wcnt <= WLOAD;
      else if (r_state == S_WAIT)                r_wcnt <= r_wcnt - 2'd1;
    end
  end

  // Write commits at the edge ending DATA, so a following read sees it.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h0;
    end else if (r_state == S_DATA && r_write) begin
      for (int b = 0; b < 4; b++)
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= Hwdata[8*b +: 8];
    end
  end

  assign Hreadyout = !((r_state == S_WAIT) || (r_state == S_ERR1));
  assign Hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
  assign Hrdata    = (r_state == S_DATA && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule

// File: doc/ahb_slave_mem.md
AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of 32-bit words in storage (power of two, 4..256).
REQ-002 SHALL have parameter WAIT_STATES, default 1, number of Hreadyout-low cycles inserted per OKAY data phase (0..3).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-004 Hclk  input  1  single clock; all state updates on rising edge.
REQ-005 Hresetn  input  1  asynchronous, active-low reset.
REQ-006 Hsel  input  1  slave select from the decoder in AHB_module.
REQ-007 Haddr  input  32  byte address, address phase.
REQ-008 Htrans  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-009 Hwrite  input  1  1=write, 0=read, address phase.
REQ-010 Hsize  input  3  transfer size: 000 byte, 001 halfword, 010 word.
REQ-011 Hwdata  input  32  write data, data phase.
REQ-012 Hready  input  1  bus-level ready; previous transfer complete.
REQ-013 Hreadyout  output  1  slave ready; low extends data phase.
REQ-014 Hresp  output  1  0=OKAY, 1=ERROR.
REQ-015 Hrdata  output  32  read data, valid when Hreadyout=1 in a read data phase.

Function
REQ-016 Transfer SHALL be accepted on a rising edge where Hsel=1, Htrans[1]=1 and Hready=1; Haddr, Hwrite and Hsize are then latched.
REQ-017 IDLE/BUSY transfers, or Hsel=0, SHALL produce no data phase; Hreadyout=1 and Hresp=0 are held.
REQ-018 FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
REQ-019 IDLE -> WAIT on accepted legal transfer if WAIT_STATES>0, otherwise -> DATA.
REQ-020 WAIT SHALL hold Hreadyout=0 for exactly WAIT_STATES cycles, then -> DATA.
REQ-021 DATA: Hreadyout=1, Hresp=0; transfer completes at end of cycle; -> IDLE, or directly to WAIT/DATA/ERR1 if a new transfer is accepted at the same edge (back-to-back, no bubble).
REQ-022 Illegal transfer = word index (Haddr-BASE_ADDR)>>2 >= DEPTH, or Haddr below BASE_ADDR, or Hsize>010, or misaligned (halfword with Haddr[0]=1, word with Haddr[1:0]!=00).
REQ-023 Illegal transfer: IDLE -> ERR1 (Hreadyout=0, Hresp=1) -> ERR2 (Hreadyout=1, Hresp=1) -> IDLE; no wait states; memory unchanged; Hrdata=0.
REQ-024 Transfer presented during ERR1 SHALL be ignored (Hready=0); during ERR2 it SHALL be accepted normally.
REQ-025 Write: Hwdata sampled at the edge ending DATA; only addressed byte lanes written, little-endian (byte lane = Haddr[1:0], halfword lanes = Haddr[1]).
REQ-026 Read: Hrdata SHALL equal the full addressed word during DATA; 32'h0 in all other states.
REQ-027 Read data phase immediately following a write to the same word SHALL return the newly written value.
REQ-028 Hwdata SHALL be ignored outside DATA of a write.

Reset
REQ-029 Hresetn=0 SHALL immediately force: state IDLE, Hreadyout=1, Hresp=0, Hrdata=0, all memory words=0, latched address/control cleared.
REQ-030 Reset mid-WAIT or mid-DATA SHALL abort the transfer with no memory write.
REQ-031 First transfer SHALL be accepted on the first rising edge with Hresetn=1.

Verification
REQ-032 Word write 32'h0000_0005 to addr 0x04, WAIT_STATES=1, then word read 0x04 -> one Hreadyout-low cycle each, Hrdata=32'h0000_0005, Hresp=0.
REQ-033 Byte write 8'hAB to 0x09 after word write 32'h1122_3344 to 0x08, then read 0x08 -> Hrdata=32'h1122_AB44.
REQ-034 Read addr 0x40 with DEPTH=16 -> Hreadyout 0 then 1 with Hresp=1 both cycles, Hrdata=0; subsequent read of 0x00 returns OKAY.
REQ-035 WAIT_STATES=0, back-to-back NONSEQ write 0x0C=32'hDEAD_BEEF then read 0x0C -> no Hreadyout-low cycles, read data phase Hrdata=32'hDEAD_BEEF.
REQ-036 Hresetn pulsed low during WAIT of write to 0x10 -> Hreadyout=1 immediately, later read of 0x10 returns 32'h0.
REQ-037 Htrans=BUSY or Hsel=0 with Hwrite=1 and Hwdata=32'hFFFF_FFFF -> Hreadyout stays 1, all memory words unchanged.
